var_delay_cal_ctrl: RTL and testbench



---
 rtl/var_delay_pkg.sv | 26 ++
 rtl/var_delay_cal_ctrl_if.sv | 27 ++
 rtl/var_delay_cal_ctrl_pd_vote.sv | 48 ++++
 rtl/var_delay_cal_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_var_delay_cal_ctrl.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/var_delay_pkg.sv
// Shared types and constants for the var_delay calibration controller.
//   SEL_W_DEF : default width of the delay_sel code
//   SEL_MAX   : largest code at the default width
//   sel_max() : largest code for an arbitrary width
//   state_e   : controller state encoding
package var_delay_pkg;

  localparam int SEL_W_DEF = 4;

  // Largest code representable in w bits
  function automatic int sel_max(input int w);
    return (32'sd1 << w) - 32'sd1;
  endfunction

  localparam int SEL_MAX = sel_max(SEL_W_DEF);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_DECIDE = 3'd3,
    ST_LOCKED = 3'd4,
    ST_TSAMP  = 3'd5
  } state_e;

endpackage

// File: rtl/var_delay_cal_ctrl_if.sv
// Control/status bundle between a host and the var_delay calibration controller.
//   master : drives start/track_en/ovr_en/ovr_sel/pd_late, observes status
//   slave  : the controller; drives delay_sel/busy/done/locked/sat
interface var_delay_cal_ctrl_if #(
  parameter int SEL_W = var_delay_pkg::SEL_W_DEF
);
  logic             start;
  logic             track_en;
  logic             ovr_en;
  logic [SEL_W-1:0] ovr_sel;
  logic             pd_late;
  logic [SEL_W-1:0] delay_sel;
  logic             busy;
  logic             done;
  logic             locked;
  logic             sat;

  modport master (
    output start, track_en, ovr_en, ovr_sel, pd_late,
    input  delay_sel, busy, done, locked, sat
  );

  modport slave (
    input  start, track_en, ovr_en, ovr_sel, pd_late,
    output delay_sel, busy, done, locked, sat
  );
endinterface

// File: rtl/var_delay_cal_ctrl_pd_vote.sv
// Majority-vote accumulator for the phase-detector "late" flag.
//   clr     : zero the running count (asserted the cycle before a vote window)
//   en      : accumulate pd_late this cycle
//   late    : running count (including this cycle's sample) exceeds NSAMP/2
//   early   : running count (including this cycle's sample) is zero
// The flags look at the next-state count so the caller can act on the last
// sample of a window in the same cycle it arrives.
module pd_vote #(
  parameter int NSAMP = 7,
  parameter int CNT_W = $clog2(NSAMP + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic pd_late,
  output logic late,
  output logic early
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next-count computation: clear wins over accumulate
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + CNT_W'(pd_late);
    end else begin
      count_d = count_q;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign late  = (count_d > CNT_W'(NSAMP / 2));
  assign early = (count_d == '0);

endmodule

// File: rtl/var_delay_cal_ctrl.sv
// SAR calibration and drift-tracking controller for a var_delay line.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of var_delay_cal_ctrl_if (start, track_en, ovr_en,
//                ovr_sel, pd_late in; delay_sel, busy, done, locked, sat out)
// One down-counter times SETTLE, SAMPLE, TSAMP and the tracking period.
module var_delay_cal_ctrl
  import var_delay_pkg::*;
#(
  parameter int SEL_W        = var_delay_pkg::SEL_W_DEF,
  parameter int SETTLE_CYC   = 16,
  parameter int NSAMP        = 7,
  parameter int TRACK_PERIOD = 256,
  parameter int DEF_SEL      = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  var_delay_cal_ctrl_if.slave bus
);

  localparam int CNT_MAX = (TRACK_PERIOD > SETTLE_CYC)
                         ? ((TRACK_PERIOD > NSAMP) ? TRACK_PERIOD : NSAMP)
                         : ((SETTLE_CYC > NSAMP) ? SETTLE_CYC : NSAMP);
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam int BIT_W = (SEL_W > 1) ? $clog2(SEL_W) : 1;

  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] SAMP_LD   = CNT_W'(NSAMP - 1);
  localparam logic [CNT_W-1:0] TRACK_LD  = CNT_W'(TRACK_PERIOD - 1);
  localparam logic [SEL_W-1:0] MAX_CODE  = SEL_W'(sel_max(SEL_W));
  localparam logic [SEL_W-1:0] DEF_CODE  = SEL_W'(DEF_SEL);
  localparam logic [SEL_W-1:0] MSB_CODE  = SEL_W'(1) << (SEL_W - 1);
  localparam logic [BIT_W-1:0] MSB_IDX   = BIT_W'(SEL_W - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             sat_q, sat_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             locked_q, locked_d;

  logic vote_clr_s;
  logic vote_en_s;
  logic vote_late_s;
  logic vote_early_s;

  assign vote_en_s = (state_q == ST_SAMPLE) || (state_q == ST_TSAMP);

  pd_vote #(.NSAMP(NSAMP)) u_vote (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (vote_clr_s),
    .en      (vote_en_s),
    .pd_late (bus.pd_late),
    .late    (vote_late_s),
    .early   (vote_early_s)
  );

  // Next-state logic: override first, then the calibration/tracking FSM
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    sel_d      = sel_q;
    sat_d      = sat_q;
    done_d     = 1'b0;
    vote_clr_s = 1'b0;

    if (bus.ovr_en) begin
      state_d = ST_IDLE;
      sel_d   = bus.ovr_sel;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_LOCKED: begin
          if (bus.start) begin
            // Fresh SAR: MSB trial with all lower bits clear
            state_d = ST_SETTLE;
            cnt_d   = SETTLE_LD;
            bit_d   = MSB_IDX;
            sel_d   = MSB_CODE;
            sat_d   = 1'b0;
          end else if (state_q == ST_IDLE) begin
            state_d = ST_IDLE;
          end else if (!bus.track_en) begin
            // Tracking off: keep the period timer parked at its reload value
            cnt_d = TRACK_LD;
          end else if (cnt_q == '0) begin
            state_d    = ST_TSAMP;
            cnt_d      = SAMP_LD;
            vote_clr_s = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end

        ST_SETTLE: begin
          if (cnt_q == '0) begin
            state_d    = ST_SAMPLE;
            cnt_d      = SAMP_LD;
            vote_clr_s = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end

        ST_SAMPLE: begin
          if (cnt_q == '0) begin
            state_d = ST_DECIDE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end

        ST_DECIDE: begin
          if (vote_late_s) begin
            sel_d[bit_q] = 1'b0;
          end else begin
            sel_d[bit_q] = sel_q[bit_q];
          end
          if (bit_q != '0) begin
            sel_d[bit_q - BIT_W'(1)] = 1'b1;
            bit_d   = bit_q - BIT_W'(1);
            state_d = ST_SETTLE;
            cnt_d   = SETTLE_LD;
          end else begin
            state_d = ST_LOCKED;
            cnt_d   = TRACK_LD;
            done_d  = 1'b1;
          end
        end

        ST_TSAMP: begin
          if (cnt_q == '0) begin
            // Last sample of the window is folded into the vote flags
            if (vote_late_s) begin
              if (sel_q == '0) begin
                sat_d = 1'b1;
              end else begin
                sel_d = sel_q - SEL_W'(1);
              end
            end else if (vote_early_s) begin
              if (sel_q == MAX_CODE) begin
                sat_d = 1'b1;
              end else begin
                sel_d = sel_q + SEL_W'(1);
              end
            end else begin
              sel_d = sel_q;
            end
            state_d = ST_LOCKED;
            cnt_d   = TRACK_LD;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end

        default: begin
          state_d = ST_IDLE;
          sel_d   = DEF_CODE;
          cnt_d   = '0;
        end
      endcase
    end

    busy_d   = (state_d == ST_SETTLE) || (state_d == ST_SAMPLE) || (state_d == ST_DECIDE);
    locked_d = (state_d == ST_LOCKED) || (state_d == ST_TSAMP);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      sel_q    <= DEF_CODE;
      sat_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      sel_q    <= sel_d;
      sat_q    <= sat_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      locked_q <= locked_d;
    end
  end

  assign bus.delay_sel = sel_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.locked    = locked_q;
  assign bus.sat       = sat_q;

endmodule

// File: tb/tb_var_delay_cal_ctrl.sv
// Self-checking bench for var_delay_cal_ctrl: table of SAR calibrations plus
// hand-written sequences for reset, tracking, saturation and override.
module tb_var_delay_cal_ctrl;

  typedef struct {
    int         thr;    // model: pd_late = (delay_sel > thr)
    int         noise;  // >=0: number of late samples forced in the MSB vote
    logic [3:0] tr0, tr1, tr2, tr3;
    logic [3:0] fin;
  } vec_t;

  logic clk;
  logic rst_n;

  var_delay_cal_ctrl_if #(.SEL_W(4)) ifc ();

  var_delay_cal_ctrl #(
    .SEL_W(4), .SETTLE_CYC(16), .NSAMP(7), .TRACK_PERIOD(256), .DEF_SEL(8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  int   nvec    = 0;
  int   nfail   = 0;
  int   cyc     = 0;
  int   t0      = 0;
  int   thr     = 10;
  int   noise_n = -1;
  bit   dither  = 1'b0;
  int   te      = 0;
  int   drops   = 0;
  int   rel_s;
  vec_t vecs[6];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Phase-detector model driven from the current code
  always_comb begin
    rel_s = cyc - t0;
    if (noise_n >= 0 && rel_s >= 16 && rel_s <= 22) begin
      ifc.pd_late = ((rel_s - 16) < noise_n);
    end else if (int'(ifc.delay_sel) > thr) begin
      ifc.pd_late = 1'b1;
    end else if (dither && int'(ifc.delay_sel) == thr) begin
      ifc.pd_late = ((cyc % 7) == 0);
    end else begin
      ifc.pd_late = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    ifc.start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    ifc.start = 1'b0;
  endtask

  task automatic advance_to(input int target);
    while (te < target) begin
      @(posedge clk);
      #1;
      te++;
      if (ifc.locked !== 1'b1) drops++;
    end
  endtask

  // Full calibration; done expected on the 96th edge after the start edge
  task automatic run_cal(input vec_t v, input int idx, input int extra_start);
    logic [3:0] tr[4];
    logic [3:0] sel_done;
    logic       busy5;
    int         done_at;
    int         done_n;
    string      p;
    p        = $sformatf("v%0d_", idx);
    thr      = v.thr;
    noise_n  = v.noise;
    dither   = 1'b0;
    done_at  = -1;
    done_n   = 0;
    sel_done = 4'd0;
    busy5    = 1'b0;
    pulse_start();
    chk({p, "start_sel"},    ifc.delay_sel, 32'd8);
    chk({p, "start_busy"},   ifc.busy,      32'd1);
    chk({p, "start_locked"}, ifc.locked,    32'd0);
    chk({p, "start_sat"},    ifc.sat,       32'd0);
    for (int k = 1; k <= 110; k++) begin
      if (k == extra_start) ifc.start = 1'b1;
      @(posedge clk);
      #1;
      ifc.start = 1'b0;
      if (ifc.done === 1'b1) begin
        done_n++;
        if (done_at < 0) begin
          done_at  = k;
          sel_done = ifc.delay_sel;
        end
      end
      if (k == 5)  busy5 = ifc.busy;
      if (k == 10) tr[0] = ifc.delay_sel;
      if (k == 34) tr[1] = ifc.delay_sel;
      if (k == 58) tr[2] = ifc.delay_sel;
      if (k == 82) tr[3] = ifc.delay_sel;
    end
    noise_n = -1;
    chk({p, "busy_settle"}, busy5, 32'd1);
    chk({p, "trial0"}, tr[0], v.tr0);
    chk({p, "trial1"}, tr[1], v.tr1);
    chk({p, "trial2"}, tr[2], v.tr2);
    chk({p, "trial3"}, tr[3], v.tr3);
    chk({p, "done_cycle"}, done_at, 32'd96);
    chk({p, "done_count"}, done_n, 32'd1);
    chk({p, "sel_at_done"}, sel_done, v.fin);
    chk({p, "final_sel"}, ifc.delay_sel, v.fin);
    chk({p, "locked"}, ifc.locked, 32'd1);
    chk({p, "busy_end"}, ifc.busy, 32'd0);
  endtask

  initial begin
    int dn;
    vecs[0] = '{10, -1, 4'd8, 4'd12, 4'd10, 4'd11, 4'd10};
    vecs[1] = '{-1, -1, 4'd8, 4'd4,  4'd2,  4'd1,  4'd0};
    vecs[2] = '{15, -1, 4'd8, 4'd12, 4'd14, 4'd15, 4'd15};
    vecs[3] = '{10,  3, 4'd8, 4'd12, 4'd10, 4'd11, 4'd10};
    vecs[4] = '{10,  4, 4'd8, 4'd4,  4'd6,  4'd7,  4'd7};
    vecs[5] = '{5,  -1, 4'd8, 4'd4,  4'd6,  4'd5,  4'd5};

    rst_n        = 1'b0;
    ifc.start    = 1'b0;
    ifc.track_en = 1'b0;
    ifc.ovr_en   = 1'b0;
    ifc.ovr_sel  = 4'd0;

    // Reset values
    #13;
    chk("rst_sel",    ifc.delay_sel, 32'd8);
    chk("rst_busy",   ifc.busy,      32'd0);
    chk("rst_done",   ifc.done,      32'd0);
    chk("rst_locked", ifc.locked,    32'd0);
    chk("rst_sat",    ifc.sat,       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Table of calibrations (later ones restart from LOCKED)
    for (int i = 0; i < 6; i++) begin
      run_cal(vecs[i], i, 0);
    end

    // Reset asserted mid-SETTLE of the bit-2 trial (code 12)
    thr = 10;
    pulse_start();
    repeat (30) begin
      @(posedge clk);
      #1;
    end
    chk("pre_rst_sel", ifc.delay_sel, 32'd12);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_sel",    ifc.delay_sel, 32'd8);
    chk("arst_busy",   ifc.busy,      32'd0);
    chk("arst_done",   ifc.done,      32'd0);
    chk("arst_locked", ifc.locked,    32'd0);
    chk("arst_sat",    ifc.sat,       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // Full calibration after release; extra start while busy is ignored
    run_cal(vecs[0], 6, 40);

    // Drift tracking: threshold moves to 8 with dither at the threshold
    @(negedge clk);
    thr          = 8;
    dither       = 1'b1;
    ifc.track_en = 1'b1;
    te           = 0;
    drops        = 0;
    advance_to(130);
    chk("trk_sel_t130", ifc.delay_sel, 32'd10);
    advance_to(400);
    chk("trk_sel_t400", ifc.delay_sel, 32'd9);
    advance_to(660);
    chk("trk_sel_t660", ifc.delay_sel, 32'd8);
    advance_to(1200);
    chk("trk_sel_hold", ifc.delay_sel, 32'd8);
    chk("trk_sat_hold", ifc.sat,       32'd0);
    thr    = -1;
    dither = 1'b0;
    advance_to(3300);
    chk("trk_sel_zero", ifc.delay_sel, 32'd0);
    chk("trk_sat_pre",  ifc.sat,       32'd0);
    advance_to(3500);
    chk("trk_sel_floor",  ifc.delay_sel, 32'd0);
    chk("trk_sat_set",    ifc.sat,       32'd1);
    chk("trk_lock_drops", drops,         32'd0);

    // Override and start together while LOCKED: override wins, sat stays
    @(negedge clk);
    ifc.ovr_en  = 1'b1;
    ifc.ovr_sel = 4'd3;
    ifc.start   = 1'b1;
    @(posedge clk);
    #1;
    chk("ovl_sel",    ifc.delay_sel, 32'd3);
    chk("ovl_locked", ifc.locked,    32'd0);
    chk("ovl_busy",   ifc.busy,      32'd0);
    chk("ovl_done",   ifc.done,      32'd0);
    chk("ovl_sat",    ifc.sat,       32'd1);
    @(negedge clk);
    ifc.start    = 1'b0;
    ifc.ovr_en   = 1'b0;
    ifc.track_en = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("ovl_sel_kept", ifc.delay_sel, 32'd3);
    chk("ovl_idle",     ifc.busy,      32'd0);

    // Override mid-SAMPLE of the MSB trial
    thr = 10;
    pulse_start();
    chk("ovs_sat_clr", ifc.sat, 32'd0);
    repeat (18) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    ifc.ovr_en  = 1'b1;
    ifc.ovr_sel = 4'd3;
    @(posedge clk);
    #1;
    chk("ovs_sel",    ifc.delay_sel, 32'd3);
    chk("ovs_busy",   ifc.busy,      32'd0);
    chk("ovs_done",   ifc.done,      32'd0);
    chk("ovs_locked", ifc.locked,    32'd0);
    @(negedge clk);
    ifc.start = 1'b1;
    @(posedge clk);
    #1;
    chk("ovs_start_busy", ifc.busy,      32'd0);
    chk("ovs_start_sel",  ifc.delay_sel, 32'd3);
    @(negedge clk);
    ifc.start  = 1'b0;
    ifc.ovr_en = 1'b0;
    dn = 0;
    repeat (110) begin
      @(posedge clk);
      #1;
      if (ifc.done !== 1'b0) dn++;
    end
    chk("ovs_no_done",  dn,            32'd0);
    chk("ovs_sel_held", ifc.delay_sel, 32'd3);
    chk("ovs_idle",     ifc.busy,      32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
